// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between instruction fetch and load/store ports
// Load/store wins ties; every access ends in IDLE so mem_req always drops for at least one cycle.
module mem_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 15,
  parameter int TO_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [WIDTH-1:0] fetch_addr,
  output logic [WIDTH-1:0] fetch_data,
  output logic             fetch_valid,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_valid,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             bus_err
);

  typedef enum logic [1:0] {IDLE, FETCH, LS} state_e;

  localparam logic [TO_BITS-1:0] TO_MAX = TO_BITS'(TIMEOUT);

  state_e             state_q, state_d;
  logic [TO_BITS-1:0] cnt_q, cnt_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0]   fetch_data_q, fetch_data_d;
  logic [WIDTH-1:0]   ls_rdata_q, ls_rdata_d;
  logic               fetch_valid_q, fetch_valid_d;
  logic               ls_valid_q, ls_valid_d;
  logic               bus_err_q, bus_err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fetch_data_q  <= '0;
      ls_rdata_q    <= '0;
      fetch_valid_q <= 1'b0;
      ls_valid_q    <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      fetch_data_q  <= fetch_data_d;
      ls_rdata_q    <= ls_rdata_d;
      fetch_valid_q <= fetch_valid_d;
      ls_valid_q    <= ls_valid_d;
      bus_err_q     <= bus_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    fetch_data_d  = fetch_data_q;
    ls_rdata_d    = ls_rdata_q;
    fetch_valid_d = 1'b0;
    ls_valid_d    = 1'b0;
    bus_err_d     = bus_err_q;
    case (state_q)
      IDLE: begin
        if (ls_req) begin
          state_d     = LS;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
        end else if (fetch_req) begin
          state_d    = FETCH;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = fetch_addr;
        end
      end
      FETCH: begin
        // An ack in the timeout cycle is still a good completion.
        if (mem_ack) begin
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          fetch_valid_d = 1'b1;
          fetch_data_d  = mem_rdata;
        end else if (cnt_q == TO_MAX) begin
          state_d       = IDLE;
          mem_req_d     = 1'b0;
          fetch_valid_d = 1'b1;
          fetch_data_d  = '0;
          bus_err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LS: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          ls_valid_d = 1'b1;
          if (!mem_we_q) ls_rdata_d = mem_rdata;
        end else if (cnt_q == TO_MAX) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          ls_valid_d = 1'b1;
          ls_rdata_d = '0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = ((state_q != IDLE) || (fetch_req || ls_req)) && !(fetch_valid_q || ls_valid_q);

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign fetch_data  = fetch_data_q;
  assign ls_rdata    = ls_rdata_q;
  assign fetch_valid = fetch_valid_q;
  assign ls_valid    = ls_valid_q;
  assign bus_err     = bus_err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles to wait for mem_ack.
REQ-003 SHALL have parameter TO_BITS, default 4, the wait-counter width (must hold TIMEOUT).
REQ-004 Ports: clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 fetch_req  in  1  instruction fetch request from the CPU PC port; held until fetch_valid.
REQ-007 fetch_addr  in  WIDTH  fetch address (mem_address_PC).
REQ-008 fetch_data  out  WIDTH  fetched word (data_from_mem_PC), registered.
REQ-009 fetch_valid  out  1  one-cycle pulse; fetch_data is valid.
REQ-010 ls_req  in  1  load/store request; held until ls_valid.
REQ-011 ls_we  in  1  1 = store, 0 = load (write_to_memory).
REQ-012 ls_addr  in  WIDTH  load/store address.
REQ-013 ls_wdata  in  WIDTH  store data.
REQ-014 ls_rdata  out  WIDTH  load data (data_from_mem_load), registered.
REQ-015 ls_valid  out  1  one-cycle pulse; load/store completed.
REQ-016 stall  out  1  CPU hold; combinational.
REQ-017 mem_req  out  1  single-port memory request, registered.
REQ-018 mem_we  out  1  memory write enable, registered.
REQ-019 mem_addr  out  WIDTH  memory address, registered.
REQ-020 mem_wdata  out  WIDTH  memory write data, registered.
REQ-021 mem_rdata  in  WIDTH  memory read data, sampled on mem_ack.
REQ-022 mem_ack  in  1  one-cycle completion strobe, arbitrary latency.
REQ-023 bus_err  out  1  sticky timeout flag.

Function
REQ-024 FSM SHALL have the states IDLE, FETCH and LS.
REQ-025 In IDLE with ls_req=1, SHALL latch ls_we, ls_addr and ls_wdata into the mem_* registers, set mem_req=1 and go to LS at the next edge; ls_req has priority over a simultaneous fetch_req.
REQ-026 In IDLE with only fetch_req=1, SHALL set mem_we=0, mem_addr=fetch_addr and mem_req=1, and go to FETCH.
REQ-027 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable while in FETCH or LS until completion.
REQ-028 In LS on mem_ack: ls_valid=1 next cycle; load SHALL capture mem_rdata into ls_rdata; store SHALL leave ls_rdata unchanged.
REQ-029 In FETCH on mem_ack: fetch_valid=1 next cycle; fetch_data SHALL capture mem_rdata.
REQ-030 On completion, mem_req SHALL drop to 0 for at least one cycle and the FSM SHALL return to IDLE; back-to-back requests are served from IDLE, minimum 2 cycles per access.
REQ-031 Wait counter: cleared on entry to FETCH or LS and incremented every cycle without mem_ack.
REQ-032 When the wait counter reaches TIMEOUT without ack: mem_req=0, the valid pulse of the active port is issued with data 0, bus_err=1 (sticky), and the FSM returns to IDLE.
REQ-033 If mem_ack coincides with the timeout cycle, SHALL treat the access as a normal completion with no error.
REQ-034 mem_ack in IDLE SHALL be ignored.
REQ-035 stall = (state!=IDLE) OR ((fetch_req OR ls_req) in IDLE), AND NOT (fetch_valid OR ls_valid).
REQ-036 fetch_valid and ls_valid SHALL never be high in the same cycle.
REQ-037 A request withdrawn before its valid pulse SHALL still complete the memory access, and its valid pulse SHALL still be issued.

Reset
REQ-038 While reset=0 (asynchronous), SHALL force state=IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fetch_data=0, ls_rdata=0, fetch_valid=0, ls_valid=0 and bus_err=0.
REQ-039 Reset asserted mid-access SHALL abort it immediately with no valid pulse; after release the FSM SHALL resume from IDLE.
REQ-040 bus_err SHALL be cleared only by reset.

Verification
REQ-041 Fetch: fetch_req=1, fetch_addr=0x0010, mem_ack after 3 cycles with mem_rdata=0xA5C3 -> mem_addr=0x0010, mem_we=0, fetch_data=0xA5C3, single fetch_valid pulse, stall low in the pulse cycle.
REQ-042 Priority: fetch_req=1 and ls_req=1 (store, 0x0200 <= 0x1234) in the same cycle -> store first (mem_we=1, mem_wdata=0x1234), ls_valid, then fetch, fetch_valid; the pulses never overlap.
REQ-043 Load: ls_we=0, ls_addr=0x0300, ack at 1 cycle with 0xBEEF -> ls_rdata=0xBEEF and ls_valid pulse, with mem_req deasserted between accesses.
REQ-044 Timeout: fetch with no ack -> after 15 wait cycles mem_req=0, fetch_valid=1 with fetch_data=0x0000, bus_err=1, which stays set through later good accesses.
REQ-045 Boundary: ack arrives exactly at count 15 -> normal completion with bus_err=0; spurious ack in IDLE -> no output change.
REQ-046 Reset in LS with a store pending -> all outputs 0 immediately, no ls_valid; a new fetch after release completes normally.
